// File: rtl/mid_ctrl_pkg.sv
// Shared types and constants for the mid-layer memory sequencer.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package mid_ctrl_pkg;

   localparam int WORD_W     = 32;
   localparam int MEM_ADR_W  = 7;
   localparam int BEAT_WORDS = 4;

   localparam int DEF_INIT_WORDS   = 64;
   localparam int DEF_READ_GROUPS  = 4;
   localparam int DEF_GROUP_STRIDE = 16;
   localparam int DEF_TIMEOUT_CYC  = 255;

   typedef enum logic [3:0] {
      ST_IDLE,
      ST_CLR,
      ST_INIT,
      ST_LIN,
      ST_CMP,
      ST_FILL,
      ST_RD,
      ST_DONE,
      ST_ERR
   } state_t;

endpackage

// File: rtl/mid_rd_agen.sv
// Read address generator: walks (g,k) and forms adr2 = z + g*GROUP_STRIDE + k (7-bit wrap).
// Latency: adr2/last combinational from the counters; counters advance one cycle after step.
// Backpressure: counters hold while step is low, so adr2 is stable during output stalls.
module mid_rd_agen
   import mid_ctrl_pkg::*;
#(
   parameter int READ_GROUPS  = DEF_READ_GROUPS,
   parameter int GROUP_STRIDE = DEF_GROUP_STRIDE
)(
   input  logic                 clk,
   input  logic                 rst,
   input  logic [MEM_ADR_W-1:0] z,
   input  logic                 step,
   input  logic                 clear,
   output logic [MEM_ADR_W-1:0] adr2,
   output logic                 last
);

   localparam int GW = (READ_GROUPS > 1) ? $clog2(READ_GROUPS) : 1;
   localparam int KW = $clog2(BEAT_WORDS);
   localparam logic [GW-1:0] G_LAST = GW'(READ_GROUPS - 1);
   localparam logic [KW-1:0] K_LAST = KW'(BEAT_WORDS - 1);

   logic [GW-1:0]        g;
   logic [KW-1:0]        k;
   logic [MEM_ADR_W-1:0] g_off;

   // (g,k) beat counters, k fastest; cleared whenever the read phase is not active
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         g <= '0;
         k <= '0;
      end else if (clear) begin
         g <= '0;
         k <= '0;
      end else if (step) begin
         if (k == K_LAST) begin
            k <= '0;
            g <= (g == G_LAST) ? '0 : g + 1'b1;
         end else begin
            k <= k + 1'b1;
         end
      end
   end

   assign g_off = MEM_ADR_W'(int'(g) * GROUP_STRIDE);
   assign adr2  = z + g_off + MEM_ADR_W'(k);
   assign last  = (g == G_LAST) && (k == K_LAST);

endmodule

// File: rtl/mid_mem_ctrl.sv
// Sequencer for the CNN mid-layer linearising memory: CLR, INIT, LIN, CMP, FILL, RD, DONE from one start pulse.
// Latency: strobes are combinational from state (LIN/FILL steps are Mealy on the done flags); one beat per accepted handshake.
// Backpressure: init_valid low stalls INIT; out_ready low holds the beat. Optional watchdog: MID_MEM_CTRL_TIMEOUT_EN.
module mid_mem_ctrl
   import mid_ctrl_pkg::*;
#(
   parameter int INIT_WORDS   = DEF_INIT_WORDS,
   parameter int READ_GROUPS  = DEF_READ_GROUPS,
   parameter int GROUP_STRIDE = DEF_GROUP_STRIDE,
   parameter int TIMEOUT_CYC  = DEF_TIMEOUT_CYC
)(
   input  logic                          clk,
   input  logic                          rst,
   input  logic                          start,
   input  logic [MEM_ADR_W-1:0]          z_cfg,
   output logic                          busy,
   output logic                          done,
   output logic                          err,
   input  logic                          init_valid,
   output logic                          init_ready,
   input  logic [WORD_W-1:0]             init_data,
   output logic                          mem_rst,
   output logic                          mem_we_init,
   output logic [WORD_W-1:0]             mem_data_init,
   output logic                          mem_lin_start,
   output logic                          mem_compute_start,
   output logic                          mem_en,
   output logic                          mem_re,
   output logic [MEM_ADR_W-1:0]          mem_adr2,
   output logic [MEM_ADR_W-1:0]          mem_z,
   input  logic                          mem_done_init,
   input  logic                          mem_done_full,
   input  logic [WORD_W-1:0]             mem_dout1,
   input  logic [WORD_W-1:0]             mem_dout2,
   input  logic [WORD_W-1:0]             mem_dout3,
   input  logic [WORD_W-1:0]             mem_dout4,
   output logic                          out_valid,
   input  logic                          out_ready,
   output logic [BEAT_WORDS*WORD_W-1:0]  out_data
);

   localparam int IW = $clog2(INIT_WORDS + 1);
   localparam logic [IW-1:0] INIT_LAST = IW'(INIT_WORDS - 1);

   if (INIT_WORDS < 1 || READ_GROUPS < 1 || TIMEOUT_CYC < 1) begin : g_bad_cfg
      $error("mid_mem_ctrl: INIT_WORDS, READ_GROUPS and TIMEOUT_CYC must be >= 1");
   end

   state_t               state;
   state_t               state_nxt;
   logic [IW-1:0]        init_cnt;
   logic [MEM_ADR_W-1:0] z_q;
   logic [MEM_ADR_W-1:0] agen_adr;
   logic                 agen_last;
   logic                 rd_step;
   logic                 wd_expired;

   assign rd_step = (state == ST_RD) && out_ready;
   assign mem_z   = z_q;

   mid_rd_agen #(
      .READ_GROUPS  (READ_GROUPS),
      .GROUP_STRIDE (GROUP_STRIDE)
   ) u_agen (
      .clk   (clk),
      .rst   (rst),
      .z     (z_q),
      .step  (rd_step),
      .clear (state != ST_RD),
      .adr2  (agen_adr),
      .last  (agen_last)
   );

   // state register
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) state <= ST_IDLE;
      else      state <= state_nxt;
   end

   // init word counter, restarted in CLR so every run writes a fresh block
   always_ff @(posedge clk or negedge rst) begin
      if (!rst)                                init_cnt <= '0;
      else if (state == ST_CLR)                init_cnt <= '0;
      else if (state == ST_INIT && init_valid) init_cnt <= init_cnt + 1'b1;
   end

   // base offset captured on an accepted start; held afterwards for the memory
   always_ff @(posedge clk or negedge rst) begin
      if (!rst)                          z_q <= '0;
      else if (state == ST_IDLE && start) z_q <= z_cfg;
   end

`ifdef MID_MEM_CTRL_TIMEOUT_EN
   localparam int WW = $clog2(TIMEOUT_CYC + 1);
   localparam logic [WW-1:0] WD_LAST = WW'(TIMEOUT_CYC - 1);

   logic [WW-1:0] wd_cnt;
   logic          wd_phase;
   logic          err_q;

   assign wd_phase   = (state == ST_LIN) || (state == ST_FILL);
   assign wd_expired = wd_phase && (wd_cnt == WD_LAST);
   assign err        = err_q;

   // watchdog: restarts on every entry into a wait phase, counts cycles spent there
   always_ff @(posedge clk or negedge rst) begin
      if (!rst)
         wd_cnt <= '0;
      else if (state_nxt != state && (state_nxt == ST_LIN || state_nxt == ST_FILL))
         wd_cnt <= '0;
      else if (wd_phase)
         wd_cnt <= wd_cnt + 1'b1;
   end

   // sticky error, cleared only by an accepted start
   always_ff @(posedge clk or negedge rst) begin
      if (!rst)                                          err_q <= 1'b0;
      else if (start && (state == ST_IDLE || state == ST_ERR)) err_q <= 1'b0;
      else if (state_nxt == ST_ERR)                      err_q <= 1'b1;
   end
`else
   assign wd_expired = 1'b0;
   assign err        = 1'b0;
`endif

   // next state and all strobes; everything defaults low so IDLE/ERR drive nothing
   always_comb begin
      state_nxt         = state;
      busy              = (state != ST_IDLE);
      done              = 1'b0;
      init_ready        = 1'b0;
      mem_rst           = 1'b0;
      mem_we_init       = 1'b0;
      mem_data_init     = '0;
      mem_lin_start     = 1'b0;
      mem_compute_start = 1'b0;
      mem_en            = 1'b0;
      mem_re            = 1'b0;
      mem_adr2          = '0;
      out_valid         = 1'b0;
      out_data          = '0;
      case (state)
         ST_IDLE: begin
            if (start) state_nxt = ST_CLR;
         end
         ST_CLR: begin
            mem_rst   = 1'b1;
            state_nxt = ST_INIT;
         end
         ST_INIT: begin
            init_ready    = 1'b1;
            mem_we_init   = init_valid;
            mem_data_init = init_data;
            if (init_valid && init_cnt == INIT_LAST) state_nxt = ST_LIN;
         end
         ST_LIN: begin
            if (mem_done_init) begin
               state_nxt = ST_CMP;
            end else begin
               mem_lin_start = 1'b1;
               if (wd_expired) state_nxt = ST_ERR;
            end
         end
         ST_CMP: begin
            mem_compute_start = 1'b1;
            state_nxt         = ST_FILL;
         end
         ST_FILL: begin
            if (mem_done_full) begin
               state_nxt = ST_RD;
            end else begin
               mem_en = 1'b1;
               if (wd_expired) state_nxt = ST_ERR;
            end
         end
         ST_RD: begin
            mem_re    = 1'b1;
            out_valid = 1'b1;
            mem_adr2  = agen_adr;
            out_data  = {mem_dout4, mem_dout3, mem_dout2, mem_dout1};
            if (out_ready && agen_last) state_nxt = ST_DONE;
         end
         ST_DONE: begin
            done      = 1'b1;
            state_nxt = ST_IDLE;
         end
         ST_ERR: begin
            if (start) state_nxt = ST_CLR;
         end
         default: state_nxt = ST_IDLE;
      endcase
   end

endmodule
